// File: rtl/fft8_bitrev_loader.sv
// Two-bank ping-pong loader: gathers 8 complex samples per frame into
// bit-reversed slot order and presents a whole frame to an 8-point DIT core.
module fft8_bitrev_loader #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_re,
    input  logic [W-1:0] s_im,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] x0_re,
    output logic [W-1:0] x0_im,
    output logic [W-1:0] x1_re,
    output logic [W-1:0] x1_im,
    output logic [W-1:0] x2_re,
    output logic [W-1:0] x2_im,
    output logic [W-1:0] x3_re,
    output logic [W-1:0] x3_im,
    output logic [W-1:0] x4_re,
    output logic [W-1:0] x4_im,
    output logic [W-1:0] x5_re,
    output logic [W-1:0] x5_im,
    output logic [W-1:0] x6_re,
    output logic [W-1:0] x6_im,
    output logic [W-1:0] x7_re,
    output logic [W-1:0] x7_im,
    output logic         err_frame,
    input  logic         err_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } bank_st_e;

    bank_st_e       st_q [2];
    bank_st_e       st_d [2];
    logic [W-1:0]   re_q [2][8];
    logic [W-1:0]   re_d [2][8];
    logic [W-1:0]   im_q [2][8];
    logic [W-1:0]   im_d [2][8];
    logic           wbank_q, wbank_d;
    logic           rbank_q, rbank_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           s_fire;
    logic           m_fire;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Handshake flags decode registered bank state only.
    assign s_ready   = (st_q[wbank_q] != ST_FULL);
    assign m_valid   = (st_q[rbank_q] == ST_FULL);
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign err_frame = err_q;

    always_comb begin
        st_d    = st_q;
        re_d    = re_q;
        im_d    = im_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (s_fire) begin
            re_d[wbank_q][bitrev3(cnt_q)] = s_re;
            im_d[wbank_q][bitrev3(cnt_q)] = s_im;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                st_d[wbank_q] = ST_FULL;
                wbank_d       = ~wbank_q;
            end else begin
                st_d[wbank_q] = ST_FILLING;
            end
            // A new framing error overrides a same-cycle clear.
            if (s_last != (cnt_q == 3'd7)) begin
                err_d = 1'b1;
            end
        end

        // Never the bank being written: a FULL bank blocks s_fire.
        if (m_fire) begin
            st_d[rbank_q] = ST_EMPTY;
            rbank_d       = ~rbank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '{default: ST_EMPTY};
            re_q    <= '{default: '0};
            im_q    <= '{default: '0};
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            re_q    <= re_d;
            im_q    <= im_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign x0_re = re_q[rbank_q][0];
    assign x0_im = im_q[rbank_q][0];
    assign x1_re = re_q[rbank_q][1];
    assign x1_im = im_q[rbank_q][1];
    assign x2_re = re_q[rbank_q][2];
    assign x2_im = im_q[rbank_q][2];
    assign x3_re = re_q[rbank_q][3];
    assign x3_im = im_q[rbank_q][3];
    assign x4_re = re_q[rbank_q][4];
    assign x4_im = im_q[rbank_q][4];
    assign x5_re = re_q[rbank_q][5];
    assign x5_im = im_q[rbank_q][5];
    assign x6_re = re_q[rbank_q][6];
    assign x6_im = im_q[rbank_q][6];
    assign x7_re = re_q[rbank_q][7];
    assign x7_im = im_q[rbank_q][7];

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Self-checking bench for fft8_bitrev_loader: directed scenarios plus
// randomized streaming against a queue-based frame model.
module tb_fft8_bitrev_loader;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_re;
    logic [W-1:0] s_im;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] x_re [8];
    logic [W-1:0] x_im [8];
    logic         err_frame;
    logic         err_clr;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q_re [$];
    logic [W-1:0] q_im [$];

    always #5 clk = ~clk;

    fft8_bitrev_loader #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_re     (s_re),
        .s_im     (s_im),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .x0_re    (x_re[0]),
        .x0_im    (x_im[0]),
        .x1_re    (x_re[1]),
        .x1_im    (x_im[1]),
        .x2_re    (x_re[2]),
        .x2_im    (x_im[2]),
        .x3_re    (x_re[3]),
        .x3_im    (x_im[3]),
        .x4_re    (x_re[4]),
        .x4_im    (x_im[4]),
        .x5_re    (x_re[5]),
        .x5_im    (x_im[5]),
        .x6_re    (x_re[6]),
        .x6_im    (x_im[6]),
        .x7_re    (x_re[7]),
        .x7_im    (x_im[7]),
        .err_frame(err_frame),
        .err_clr  (err_clr)
    );

    // Slot k of an output frame holds arrival index bitrev3(k).
    function automatic int br(input int k);
        return ((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        s_valid = 0; s_re = '0; s_im = '0; s_last = 0; m_ready = 0; err_clr = 0;
        rst_n = 0;
        repeat (2) tick;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid);
        end
        checks++;
        if (err_frame !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err_frame);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_re[k] !== '0 || x_im[k] !== '0) begin
                errors++;
                $display("FAIL reset_x%0d: got re=%h im=%h expected 0", k, x_re[k], x_im[k]);
            end
        end
        rst_n = 1;
        tick;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
    endtask

    task automatic test_first_frame;
        m_ready = 0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1; s_re = W'(n); s_im = W'(0) - W'(n); s_last = (n == 7);
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL first_s_ready n=%0d: got %b expected 1", n, s_ready);
            end
            tick;
        end
        s_valid = 0; s_last = 0;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL first_m_valid: got %b expected 1", m_valid);
        end
        checks++;
        if (err_frame !== 1'b0) begin
            errors++; $display("FAIL first_err: got %b expected 0", err_frame);
        end
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] er, ei;
            er = W'(br(k));
            ei = W'(0) - er;
            checks++;
            if (x_re[k] !== er || x_im[k] !== ei) begin
                errors++;
                $display("FAIL first_slot%0d: got re=%h im=%h expected re=%h im=%h",
                         k, x_re[k], x_im[k], er, ei);
            end
        end
        m_ready = 1;
        tick;
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL first_release: m_valid got %b expected 0", m_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] fr [16];
        logic [W-1:0] fi [16];
        int bad;
        m_ready = 0;
        for (int i = 0; i < 16; i++) begin
            fr[i] = W'($urandom); fi[i] = W'($urandom);
            s_valid = 1; s_re = fr[i]; s_im = fi[i]; s_last = ((i % 8) == 7);
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL bp_s_ready i=%0d: got %b expected 1", i, s_ready);
            end
            tick;
        end
        // Keep offering data while both banks are full; none may be taken.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_re = W'($urandom); s_im = W'($urandom); s_last = 0;
            checks++;
            if (s_ready !== 1'b0) begin
                errors++; $display("FAIL bp_full_s_ready cyc=%0d: got %b expected 0", i, s_ready);
            end
            tick;
        end
        s_valid = 0;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL bp_m_valid: got %b expected 1", m_valid);
        end
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (x_re[k] !== fr[br(k)] || x_im[k] !== fi[br(k)]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_frame0_frozen: got %0d bad slots expected 0", bad);
        end
        m_ready = 1;
        tick;
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_release: got m_valid=%b s_ready=%b expected 1 1", m_valid, s_ready);
        end
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (x_re[k] !== fr[8 + br(k)] || x_im[k] !== fi[8 + br(k)]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_frame1: got %0d bad slots expected 0", bad);
        end
        m_ready = 1;
        tick;
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: m_valid got %b expected 0", m_valid);
        end
    endtask

    task automatic test_stream(input int nframes, input int vpct, input int rpct,
                               input bit must_ready, input string tag);
        int nin, nout, cyc, budget, bad;
        nin = 0; nout = 0; cyc = 0; bad = 0;
        budget = nframes * 8 * 20 + 50;
        q_re.delete(); q_im.delete();
        err_clr = 0;
        while (nout < nframes && cyc < budget) begin
            s_valid = (nin < nframes * 8) && (int'($urandom_range(99)) < vpct);
            s_re = W'($urandom); s_im = W'($urandom);
            s_last = ((nin % 8) == 7);
            m_ready = (int'($urandom_range(99)) < rpct);
            if (must_ready && nin < nframes * 8) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++; $display("FAIL %s_s_ready cyc=%0d: got %b expected 1", tag, cyc, s_ready);
                end
            end
            if (s_valid && s_ready) begin
                q_re.push_back(s_re); q_im.push_back(s_im); nin++;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (q_re.size() < 8) begin
                    errors++;
                    $display("FAIL %s_spurious_frame %0d: got frame with %0d samples queued expected 8",
                             tag, nout, q_re.size());
                end else begin
                    bad = 0;
                    for (int k = 0; k < 8; k++)
                        if (x_re[k] !== q_re[br(k)] || x_im[k] !== q_im[br(k)]) bad++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL %s_frame %0d: got %0d bad slots expected 0 (x0 re=%h want %h)",
                                 tag, nout, bad, x_re[0], q_re[0]);
                    end
                    repeat (8) begin
                        void'(q_re.pop_front()); void'(q_im.pop_front());
                    end
                end
                nout++;
            end
            tick;
            cyc++;
        end
        s_valid = 0; m_ready = 0; s_last = 0;
        checks++;
        if (nout != nframes) begin
            errors++; $display("FAIL %s_timeout: got %0d frames expected %0d", tag, nout, nframes);
        end
        checks++;
        if (q_re.size() != 0) begin
            errors++; $display("FAIL %s_leftover: got %0d samples unemitted expected 0", tag, q_re.size());
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL %s_extra_frame: m_valid got %b expected 0", tag, m_valid);
        end
        checks++;
        if (err_frame !== 1'b0) begin
            errors++; $display("FAIL %s_err: got %b expected 0", tag, err_frame);
        end
    endtask

    task automatic test_framing_error;
        m_ready = 0; err_clr = 0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1; s_re = W'(n); s_im = W'(0) - W'(n);
            s_last = (n == 3) || (n == 7);
            tick;
            if (n == 2) begin
                checks++;
                if (err_frame !== 1'b0) begin
                    errors++; $display("FAIL err_early: got %b expected 0", err_frame);
                end
            end
            if (n == 3) begin
                checks++;
                if (err_frame !== 1'b1) begin
                    errors++; $display("FAIL err_set_n3: got %b expected 1", err_frame);
                end
            end
        end
        s_valid = 0; s_last = 0;
        checks++;
        if (m_valid !== 1'b1 || err_frame !== 1'b1) begin
            errors++;
            $display("FAIL err_frame_done: got m_valid=%b err=%b expected 1 1", m_valid, err_frame);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_re[k] !== W'(br(k))) begin
                errors++; $display("FAIL err_slot%0d: got re=%h expected %h", k, x_re[k], W'(br(k)));
            end
        end
        err_clr = 1;
        tick;
        err_clr = 0;
        checks++;
        if (err_frame !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", err_frame);
        end
        m_ready = 1;
        tick;
        m_ready = 0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1; s_re = W'(n + 100); s_im = W'(n); s_last = (n == 0);
            err_clr = (n <= 1);
            tick;
            if (n == 0) begin
                checks++;
                if (err_frame !== 1'b1) begin
                    errors++; $display("FAIL err_clr_vs_new: got %b expected 1", err_frame);
                end
            end
            if (n == 6) begin
                checks++;
                if (err_frame !== 1'b0) begin
                    errors++; $display("FAIL err_cleared_mid: got %b expected 0", err_frame);
                end
            end
            if (n == 7) begin
                checks++;
                if (err_frame !== 1'b1) begin
                    errors++; $display("FAIL err_missing_last: got %b expected 1", err_frame);
                end
            end
        end
        s_valid = 0; err_clr = 0;
        checks++;
        if (m_valid !== 1'b1 || x_re[1] !== W'(104)) begin
            errors++;
            $display("FAIL err_frame2: got m_valid=%b x1_re=%h expected 1 %h", m_valid, x_re[1], W'(104));
        end
        m_ready = 1; err_clr = 1;
        tick;
        m_ready = 0; err_clr = 0;
    endtask

    task automatic test_reset_mid;
        m_ready = 0;
        for (int i = 0; i < 13; i++) begin
            s_valid = 1; s_re = W'($urandom) | W'(1); s_im = W'($urandom) | W'(1);
            s_last = ((i % 8) == 7);
            tick;
        end
        s_valid = 0; s_last = 0;
        rst_n = 0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_m_valid: got %b expected 0", m_valid);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_re[k] !== '0 || x_im[k] !== '0) begin
                errors++;
                $display("FAIL midreset_x%0d: got re=%h im=%h expected 0", k, x_re[k], x_im[k]);
            end
        end
        tick;
        rst_n = 1;
        tick;
        test_stream(1, 100, 100, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_backpressure;
        test_stream(8, 100, 100, 1'b1, "throughput");
        test_framing_error;
        test_stream(6, 60, 50, 1'b0, "random_a");
        test_stream(10, 85, 30, 1'b0, "random_b");
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft8_bitrev_loader.md
FFT8_BITREV_LOADER -- requirements
Module: fft8_bitrev_loader

Interface
REQ-001 Parameter W, default 16: sample component width, signed Q1.15 at default.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 s_valid  input  1  upstream sample valid.
REQ-005 s_ready  output  1  loader can accept a sample this cycle.
REQ-006 s_re, s_im  input  W each  signed sample real/imag.
REQ-007 s_last  input  1  upstream marks the 8th sample of a frame.
REQ-008 m_valid  output  1  complete bit-reversed frame presented.
REQ-009 m_ready  input  1  downstream 8-point DIT core consumes frame.
REQ-010 x0_re, x0_im ... x7_re, x7_im  output  W each  flat frame, slot k = sample bitrev3(k).
REQ-011 err_frame  output  1  sticky framing-error flag.
REQ-012 err_clr  input  1  synchronous clear of err_frame.

Function
REQ-013 Loader SHALL hold two banks (A, B), each eight complex W-bit slots plus state EMPTY/FILLING/FULL.
REQ-014 Write pointer wbank and read pointer rbank SHALL both reset to bank A.
REQ-015 Sample transfer SHALL occur exactly on s_valid && s_ready at a rising edge.
REQ-016 Transfer index n (0..7, 3-bit counter) SHALL write the sample into slot bitrev3(n) of wbank: n=0..7 -> slots 0,4,2,6,1,5,3,7.
REQ-017 First transfer into an EMPTY bank SHALL move it to FILLING; transfer n=7 SHALL move it to FULL, wrap the counter to 0 and toggle wbank in the same edge.
REQ-018 s_ready SHALL equal (state of wbank != FULL), decoded from registers only, with no combinational path from s_valid or m_ready.
REQ-019 m_valid SHALL equal (state of rbank == FULL), registered.
REQ-020 On m_valid && m_ready, rbank SHALL become EMPTY and rbank SHALL toggle at that edge.
REQ-021 Completing a write into one bank and releasing the other bank in the same edge SHALL both take effect, with no lost frame or sample.
REQ-022 If both banks are FULL, s_ready SHALL be 0 until a release; the released bank is writable from the next cycle.
REQ-023 x*_re/x*_im SHALL be driven directly from rbank slot registers.
REQ-024 Outputs SHALL be stable while m_valid && !m_ready.
REQ-025 Latency: last sample accepted at edge t -> m_valid high after edge t (visible cycle t+1); sustained throughput one sample per clock with m_ready held high.
REQ-026 err_frame SHALL set when s_last=1 on a transfer with n!=7, or s_last=0 on a transfer with n=7.
REQ-027 A framing error SHALL NOT alter counting; the frame still completes at n=7 (no resync).
REQ-028 err_clr SHALL clear err_frame; a simultaneous new error SHALL win (flag stays 1).
REQ-029 Data SHALL pass bit-exact; no scaling, rounding or sign handling.

Reset
REQ-030 While rst_n=0: both banks EMPTY, all slots 0, counter 0, wbank=rbank=A, m_valid=0, err_frame=0, all x* outputs 0.
REQ-031 s_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-frame or with frames pending SHALL discard all partial and full frames without emitting them.

Verification
REQ-033 Reset, then 8 transfers with samples re=n, im=-n and s_last on n=7 -> m_valid at the next cycle; x0..x7_re = 0,4,2,6,1,5,3,7; im negated; err_frame=0.
REQ-034 m_ready=0, stream 16 samples back-to-back -> s_ready falls after the 16th transfer; m_valid=1 with outputs frozen; m_ready=1 for one cycle -> second frame presented next cycle and s_ready=1.
REQ-035 m_ready held 1, 64 continuous samples -> 8 frames out, s_ready never deasserts, each frame bit-reversed correctly.
REQ-036 s_last at n=3 -> err_frame=1 from the next cycle; frame still emitted after n=7; err_clr pulse -> err_frame=0.
REQ-037 Assert rst_n=0 after 5 transfers -> m_valid=0, outputs 0; the next 8 samples form a clean frame.
REQ-038 Random s_valid/m_ready throttling against a reference model -> every frame matches; no sample is dropped or duplicated.
